// File: rtl/rr_reg_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : arb_pkg                                                      |
// | Desc   : Shared state encoding and helpers for rr_reg_arbiter.        |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package arb_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_reg_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_reg_arbiter_if                                            |
// | Desc   : Requester and consumer handshake bundle of the arbiter.      |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
interface rr_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = arb_pkg::clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       q;
    logic [SRC_W-1:0]       q_src;
    logic                   q_valid;
    logic                   q_ready;

    modport master (
        output req_valid, req_data, q_ready,
        input  req_ready, q, q_src, q_valid
    );

    modport slave (
        input  req_valid, req_data, q_ready,
        output req_ready, q, q_src, q_valid
    );
endinterface : rr_reg_arbiter_if
`default_nettype wire

// File: rtl/rr_reg_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_pick                                                      |
// | Desc   : Combinational round-robin picker scanning upward from ptr.   |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [SRC_W-1:0] ptr,
    input  wire logic             en,
    output logic      [N_REQ-1:0] gnt_onehot,
    output logic      [SRC_W-1:0] gnt_idx,
    output logic                  any
);
    int   w_idx;
    logic w_found;

    always_comb begin
        w_found    = 1'b0;
        w_idx      = 0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req[w_idx[SRC_W-1:0]]) begin
                w_found = 1'b1;
                gnt_idx = w_idx[SRC_W-1:0];
            end
        end
        any = w_found;
        // Index is still reported when en is low; only the one-hot grant is gated.
        for (int i = 0; i < N_REQ; i++) begin
            gnt_onehot[i] = en & w_found & (gnt_idx == SRC_W'(i));
        end
    end
endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_reg_arbiter                                               |
// | Desc   : Round-robin shared register with valid/ready consumer side.  |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module rr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    rr_reg_arbiter_if.slave  bus
);
    localparam int SRC_W = clog2(N_REQ);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [WIDTH-1:0] r_q;
    logic [SRC_W-1:0] r_q_src;

    logic             w_can_accept;
    logic             w_pick_en;
    logic [N_REQ-1:0] w_gnt_onehot;
    logic [SRC_W-1:0] w_gnt_idx;
    logic             w_any;
    logic             w_accept;
    logic [WIDTH-1:0] w_data [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_data[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req        (bus.req_valid),
        .ptr        (r_rr_ptr),
        .en         (w_pick_en),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && bus.q_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Output / handshake decode; grants are suppressed while reset is held.
    always_comb begin
        w_can_accept  = (r_state == ST_EMPTY) | bus.q_ready;
        w_pick_en     = rstn & w_can_accept;
        w_accept      = w_pick_en & w_any;
        bus.req_ready = w_gnt_onehot;
        bus.q_valid   = (r_state == ST_FULL);
        bus.q         = r_q;
        bus.q_src     = r_q_src;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q      <= '0;
            r_q_src  <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_q      <= w_data[w_gnt_idx];
            r_q_src  <= w_gnt_idx;
            r_rr_ptr <= (w_gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
        end
    end
endmodule : rr_reg_arbiter
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_rr_reg_arbiter                                            |
// | Desc   : Directed self-checking bench for rr_reg_arbiter.             |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_rr_reg_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    rr_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    rr_reg_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] val);
        bus.req_data[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset with every requester active
        rstn          = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.q_ready   = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'h10 + 8'(i));
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_q",         32'(bus.q),         32'h0);
        chk("rst_q_src",     32'(bus.q_src),     32'h0);
        chk("rst_q_valid",   32'(bus.q_valid),   32'h0);

        // Single write from requester 2
        rstn          = 1'b1;
        bus.req_valid = 4'b0100;
        set_data(2, 8'hA5);
        #1;
        chk("single_grant", 32'(bus.req_ready), 32'h4);
        tick();
        chk("single_q",       32'(bus.q),       32'hA5);
        chk("single_q_src",   32'(bus.q_src),   32'h2);
        chk("single_q_valid", 32'(bus.q_valid), 32'h1);

        // Backpressure: requester 1 waits while the word is unconsumed
        bus.req_valid = 4'b0010;
        set_data(1, 8'h5A);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            tick();
            chk("bp_q_stable", 32'(bus.q),       32'hA5);
            chk("bp_q_valid",  32'(bus.q_valid), 32'h1);
        end
        bus.q_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.req_ready), 32'h2);
        tick();
        chk("bp_q",       32'(bus.q),       32'h5A);
        chk("bp_q_src",   32'(bus.q_src),   32'h1);
        chk("bp_q_valid", 32'(bus.q_valid), 32'h1);

        // Consume without a new request: word and source are retained
        bus.req_valid = 4'b0000;
        tick();
        chk("consume_q_valid", 32'(bus.q_valid), 32'h0);
        chk("consume_q",       32'(bus.q),       32'h5A);
        chk("consume_q_src",   32'(bus.q_src),   32'h1);

        // Grant requester 3 so the pointer wraps to 0
        bus.req_valid = 4'b1000;
        set_data(3, 8'h13);
        #1;
        chk("pre_rr_grant", 32'(bus.req_ready), 32'h8);
        tick();
        chk("pre_rr_q_src", 32'(bus.q_src), 32'h3);

        // Round-robin with all valid and a consumer that never stalls
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_q_src",   32'(bus.q_src),   32'(k % 4));
            chk("rr_q",       32'(bus.q),       32'(8'h10 + 8'(k % 4)));
            chk("rr_q_valid", 32'(bus.q_valid), 32'h1);
        end

        // Pointer is at 1: grant 2 moves it to 3, then 1001 wraps 3 -> 0
        bus.req_valid = 4'b0100;
        #1;
        chk("wrap_pre_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b1001;
        set_data(3, 8'h33);
        set_data(0, 8'h30);
        #1;
        chk("wrap_grant3", 32'(bus.req_ready), 32'h8);
        tick();
        chk("wrap_q3",     32'(bus.q),     32'h33);
        chk("wrap_q_src3", 32'(bus.q_src), 32'h3);
        bus.req_valid = 4'b0001;
        #1;
        chk("wrap_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        chk("wrap_q0",     32'(bus.q),     32'h30);
        chk("wrap_q_src0", 32'(bus.q_src), 32'h0);

        // Reset while FULL with every requester active
        bus.q_ready   = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'h40 + 8'(i));
        rstn = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mid_rst_q_valid", 32'(bus.q_valid), 32'h0);
        chk("mid_rst_q",       32'(bus.q),       32'h0);
        chk("mid_rst_q_src",   32'(bus.q_src),   32'h0);
        rstn = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        tick();
        chk("post_rst_q",       32'(bus.q),       32'h40);
        chk("post_rst_q_src",   32'(bus.q_src),   32'h0);
        chk("post_rst_q_valid", 32'(bus.q_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_rr_reg_arbiter
`default_nettype wire
